imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 120 ++++++++++++
 tb/tb_imem_loader.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Instruction-memory boot loader. Takes a framed byte stream
// (0xA5 sync, 16-bit little-endian word count, little-endian words,
// 8-bit additive checksum), writes each word into instruction memory,
// and releases the core reset only when the image checks out.
module imem_loader #(
    parameter int ADDR_W    = 10,
    parameter int MAX_WORDS = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst,
    input  logic              start,
    output logic              load_done,
    output logic              load_error
);

    typedef enum logic [2:0] {
        IDLE, LEN0, LEN1, DATA, CSUM, DONE, ERROR
    } state_t;

    // Word counter is one bit wider than the 16-bit length so a full
    // 65535-word compare never wraps.
    localparam int CNT_W = 17;
    localparam logic [CNT_W-1:0] MAX_W = CNT_W'(MAX_WORDS);

    state_t           state;
    logic [1:0]       byteCnt;
    logic [CNT_W-1:0] wordCnt;
    logic [15:0]      len;
    logic [7:0]       sum;
    logic [23:0]      wordBuf;

    logic             accept;
    logic [15:0]      lenNext;

    assign accept  = rx_valid & rx_ready;
    assign lenNext = {rx_data, len[7:0]};

    // Status outputs decode straight from the state register, so
    // core_rst and load_done rise on the very edge that enters DONE.
    assign rx_ready   = (state != DONE) && (state != ERROR);
    assign core_rst   = (state == DONE);
    assign load_done  = (state == DONE);
    assign load_error = (state == ERROR);

    // Frame parser, word assembler, memory write port and checksum.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            byteCnt    <= '0;
            wordCnt    <= '0;
            len        <= '0;
            sum        <= '0;
            wordBuf    <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
        end else begin
            imem_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept && rx_data == 8'hA5) state <= LEN0;
                end
                LEN0: begin
                    if (accept) begin
                        len[7:0] <= rx_data;
                        state    <= LEN1;
                    end
                end
                LEN1: begin
                    if (accept) begin
                        len[15:8] <= rx_data;
                        if ({1'b0, lenNext} > MAX_W) state <= ERROR;
                        else if (lenNext == 16'd0)   state <= CSUM;
                        else                         state <= DATA;
                    end
                end
                DATA: begin
                    if (accept) begin
                        sum     <= sum + rx_data;
                        byteCnt <= byteCnt + 2'd1;
                        case (byteCnt)
                            2'd0: wordBuf[7:0]   <= rx_data;
                            2'd1: wordBuf[15:8]  <= rx_data;
                            2'd2: wordBuf[23:16] <= rx_data;
                            2'd3: begin
                                imem_we    <= 1'b1;
                                imem_addr  <= ADDR_W'(wordCnt);
                                imem_wdata <= {rx_data, wordBuf};
                                wordCnt    <= wordCnt + 1'b1;
                                if (wordCnt + 1'b1 == {1'b0, len}) state <= CSUM;
                            end
                        endcase
                    end
                end
                CSUM: begin
                    if (accept) state <= (rx_data == sum) ? DONE : ERROR;
                end
                DONE, ERROR: begin
                    if (start) begin
                        state   <= IDLE;
                        byteCnt <= '0;
                        wordCnt <= '0;
                        len     <= '0;
                        sum     <= '0;
                        wordBuf <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: good image, bad checksum, oversize
// length, empty image, gapped stream and mid-load reset.
module tb_imem_loader;

    localparam int ADDR_W = 10;

    logic              clk;
    logic              rst;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_rst;
    logic              start;
    logic              load_done;
    logic              load_error;

    imem_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(1024)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_rst   (core_rst),
        .start      (start),
        .load_done  (load_done),
        .load_error (load_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passes = 0;
    int total  = 0;

    // Write log captured on the falling edge, plus a count of writes
    // that stayed high for more than one cycle.
    logic [ADDR_W-1:0] wrAddr [64];
    logic [31:0]       wrData [64];
    int                wrCount   = 0;
    int                longPulse = 0;
    logic              weLast    = 1'b0;

    always @(negedge clk) begin
        if (imem_we) begin
            if (wrCount < 64) begin
                wrAddr[wrCount] = imem_addr;
                wrData[wrCount] = imem_wdata;
            end
            wrCount = wrCount + 1;
            if (weLast) longPulse = longPulse + 1;
        end
        weLast = imem_we;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic sendByte(input logic [7:0] b, input int gap);
        for (int g = 0; g < gap; g++) @(posedge clk);
        #1;
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic pulseStart();
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    logic [7:0] good [13];
    int base;
    int base2;

    task automatic sendGood(input logic [7:0] last, input int maxGap);
        for (int i = 0; i < 12; i++) sendByte(good[i], $urandom_range(0, maxGap));
        sendByte(last, $urandom_range(0, maxGap));
        @(posedge clk);
        #1;
    endtask

    task automatic chkGoodWrites(input string tag, input int b);
        chk({tag, "_nwr"},   32'(wrCount - b), 32'd2);
        chk({tag, "_addr0"}, 32'(wrAddr[b]),   32'd0);
        chk({tag, "_data0"}, wrData[b],        32'h0000_0013);
        chk({tag, "_addr1"}, 32'(wrAddr[b+1]), 32'd1);
        chk({tag, "_data1"}, wrData[b+1],      32'h0010_0093);
    endtask

    initial begin
        good = '{8'h00, 8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                 8'h93, 8'h00, 8'h10, 8'h00, 8'hB6};
        rst = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; start = 1'b0;

        // Reset state
        #12;
        chk("rst_ready", 32'(rx_ready),   32'd1);
        chk("rst_we",    32'(imem_we),    32'd0);
        chk("rst_addr",  32'(imem_addr),  32'd0);
        chk("rst_wdata", imem_wdata,      32'd0);
        chk("rst_core",  32'(core_rst),   32'd0);
        chk("rst_done",  32'(load_done),  32'd0);
        chk("rst_err",   32'(load_error), 32'd0);
        @(posedge clk); #1 rst = 1'b1;

        // start in IDLE is ignored
        pulseStart();
        chk("idle_start_ready", 32'(rx_ready), 32'd1);

        // Good image
        base = wrCount;
        sendGood(8'hB6, 0);
        chkGoodWrites("good", base);
        chk("good_done",  32'(load_done),  32'd1);
        chk("good_core",  32'(core_rst),   32'd1);
        chk("good_err",   32'(load_error), 32'd0);
        chk("good_ready", 32'(rx_ready),   32'd0);

        // Bad checksum
        pulseStart();
        chk("restart_ready", 32'(rx_ready), 32'd1);
        chk("restart_core",  32'(core_rst), 32'd0);
        base = wrCount;
        sendGood(8'hB7, 0);
        chkGoodWrites("bad", base);
        chk("bad_err",   32'(load_error), 32'd1);
        chk("bad_core",  32'(core_rst),   32'd0);
        chk("bad_ready", 32'(rx_ready),   32'd0);

        // Oversize length 1025
        pulseStart();
        base = wrCount;
        sendByte(8'hA5, 0); sendByte(8'h01, 0); sendByte(8'h04, 0);
        #1;
        chk("big_err",   32'(load_error), 32'd1);
        chk("big_nwr",   32'(wrCount - base), 32'd0);
        pulseStart();
        chk("big_ready", 32'(rx_ready),   32'd1);
        chk("big_clr",   32'(load_error), 32'd0);

        // Max length 1024 is accepted into DATA (not ERROR)
        sendByte(8'hA5, 0); sendByte(8'h00, 0); sendByte(8'h04, 0);
        chk("max_noerr", 32'(load_error), 32'd0);
        chk("max_ready", 32'(rx_ready),   32'd1);
        rst = 1'b0; #2; rst = 1'b1;

        // Empty image, good and bad checksum
        base = wrCount;
        sendByte(8'hA5, 0); sendByte(8'h00, 0); sendByte(8'h00, 0); sendByte(8'h00, 0);
        chk("empty_done", 32'(load_done), 32'd1);
        chk("empty_nwr",  32'(wrCount - base), 32'd0);
        pulseStart();
        sendByte(8'hA5, 0); sendByte(8'h00, 0); sendByte(8'h00, 0); sendByte(8'h01, 0);
        chk("empty_bad", 32'(load_error), 32'd1);

        // Gapped stream
        pulseStart();
        base  = wrCount;
        base2 = longPulse;
        sendGood(8'hB6, 3);
        chkGoodWrites("gap", base);
        chk("gap_done",  32'(load_done),        32'd1);
        chk("gap_pulse", 32'(longPulse - base2), 32'd0);

        // Reset mid-load after the second data byte
        pulseStart();
        base = wrCount;
        for (int i = 1; i < 6; i++) sendByte(good[i], 0);
        rst = 1'b0;
        #2;
        chk("mid_ready", 32'(rx_ready), 32'd1);
        chk("mid_we",    32'(imem_we),  32'd0);
        @(posedge clk); @(posedge clk); #1;
        chk("mid_nwr", 32'(wrCount - base), 32'd0);
        rst = 1'b1;
        // Remaining bytes of the abandoned word must not complete a write.
        sendByte(8'h00, 0); sendByte(8'h00, 0);
        chk("mid_nwr2", 32'(wrCount - base), 32'd0);
        base = wrCount;
        sendGood(8'hB6, 0);
        chkGoodWrites("post", base);
        chk("post_done", 32'(load_done), 32'd1);
        chk("post_core", 32'(core_rst),  32'd1);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
